// File: rtl/register_file_mp_pkg.sv
// Shared types and constants for the multi-port vector register file and the
// double-buffered ternary-matrix register.
//
// Contents:
//   VectorWidth / vector_t        : one vector register word
//   NumVectorRegisters            : default register count
//   VecAddrWidth                  : register index width for the default count
//   MatrixCols / MatrixRows       : default ternary matrix geometry
//   trit_t / ternary_row_t        : 2-bit trit and one packed matrix row
//   ternary_matrix_t              : a full matrix of MatrixRows rows
//   Trit* constants               : trit encodings used by the datapath
package register_file_mp_pkg;

  localparam int VectorWidth        = 32;
  localparam int NumVectorRegisters = 8;
  localparam int VecAddrWidth       = $clog2(NumVectorRegisters);

  localparam int MatrixCols = 8;
  localparam int MatrixRows = 16;

  typedef logic [VectorWidth-1:0] vector_t;

  // Two bits per matrix element: 00 = 0, 01 = +1, 11 = -1 (10 unused).
  typedef logic [1:0] trit_t;

  localparam trit_t TritZero = 2'b00;
  localparam trit_t TritPos  = 2'b01;
  localparam trit_t TritNeg  = 2'b11;

  typedef trit_t [MatrixCols-1:0] ternary_row_t;
  typedef ternary_row_t [MatrixRows-1:0] ternary_matrix_t;

  // Width of the row counter for a matrix of 'rows' rows; never below 1 bit.
  function automatic int row_cnt_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/register_file_mp_tm_double_buffer.sv
// Double-buffered ternary-matrix register.
//
// A shadow buffer is filled row by row over a valid/ready stream. Once the
// last row lands, the shadow is marked full and is promoted to the active
// buffer on a later edge, as soon as the active buffer is free (empty, or
// released by the consumer in that same cycle).
//
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   row_valid_i       : row beat valid
//   row_ready_o       : shadow buffer can take a row (= !shadow_full)
//   row_data_i        : one matrix row
//   abort_i           : drop shadow contents, restart row count, block swap
//   release_i         : consumer done with the active matrix
//   active_valid_o    : active buffer holds a complete matrix
//   active_o          : active matrix (row 0 in the least significant slot)
module tm_double_buffer
  import register_file_mp_pkg::*;
#(
  parameter int MatrixRows = register_file_mp_pkg::MatrixRows
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           row_valid_i,
  output logic                           row_ready_o,
  input  ternary_row_t                   row_data_i,
  input  logic                           abort_i,
  input  logic                           release_i,
  output logic                           active_valid_o,
  output ternary_row_t [MatrixRows-1:0]  active_o
);

  localparam int CntWidth = row_cnt_width(MatrixRows);
  localparam logic [CntWidth-1:0] LastRow = CntWidth'(MatrixRows - 1);

  ternary_row_t [MatrixRows-1:0] shadow_q, shadow_d;
  ternary_row_t [MatrixRows-1:0] active_q, active_d;
  logic [CntWidth-1:0]           row_cnt_q, row_cnt_d;
  logic                          shadow_full_q, shadow_full_d;
  logic                          active_valid_q, active_valid_d;

  logic row_hs;
  logic do_swap;

  assign row_ready_o    = !shadow_full_q;
  assign active_valid_o = active_valid_q;
  assign active_o       = active_q;

  // A beat that coincides with an abort is dropped, so it never advances
  // the counter or lands in the shadow buffer.
  assign row_hs  = row_valid_i && !shadow_full_q && !abort_i;

  // Swap uses the registered full flag, so the last row is always visible in
  // shadow_q before it is copied across.
  assign do_swap = shadow_full_q && (!active_valid_q || release_i) && !abort_i;

  always_comb begin
    shadow_d       = shadow_q;
    active_d       = active_q;
    row_cnt_d      = row_cnt_q;
    shadow_full_d  = shadow_full_q;
    active_valid_d = active_valid_q;

    if (row_hs) begin
      shadow_d[row_cnt_q] = row_data_i;
      if (row_cnt_q == LastRow) begin
        row_cnt_d     = '0;
        shadow_full_d = 1'b1;
      end else begin
        row_cnt_d = row_cnt_q + 1'b1;
      end
    end

    if (abort_i) begin
      row_cnt_d     = '0;
      shadow_full_d = 1'b0;
    end

    // Release with a pending full shadow turns into a back-to-back swap, so
    // active_valid never drops; release alone just frees the active slot and
    // leaves its data in place.
    if (do_swap) begin
      active_d       = shadow_q;
      active_valid_d = 1'b1;
      shadow_full_d  = 1'b0;
    end else if (release_i) begin
      active_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q       <= '0;
      active_q       <= '0;
      row_cnt_q      <= '0;
      shadow_full_q  <= 1'b0;
      active_valid_q <= 1'b0;
    end else begin
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      row_cnt_q      <= row_cnt_d;
      shadow_full_q  <= shadow_full_d;
      active_valid_q <= active_valid_d;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port vector register file with a per-register valid scoreboard, plus
// a double-buffered ternary-matrix register for the matmul datapath.
//
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   rd_addr_i          : read index per read port
//   rd_data_o          : stored vector per read port (combinational, no bypass)
//   rd_valid_o         : scoreboard valid bit of the addressed register
//   wr_en_i            : write enable per write port
//   wr_addr_i          : write index per write port
//   wr_data_i          : write data per write port
//   inv_i              : per-register valid clear (data untouched)
//   tm_row_valid_i     : matrix row beat valid
//   tm_row_ready_o     : shadow matrix buffer can accept a row
//   tm_row_data_i      : one matrix row
//   tm_abort_i         : discard shadow contents and restart the row count
//   tm_release_i       : consumer finished with the active matrix
//   tm_active_valid_o  : active matrix holds a complete matrix
//   tm_data_o          : active matrix
//
// The vector path and the matrix path share only clock and reset.
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int NumVectorRegisters = register_file_mp_pkg::NumVectorRegisters,
  parameter int NumReadPorts       = 2,
  parameter int NumWritePorts      = 2,
  parameter int MatrixRows         = register_file_mp_pkg::MatrixRows,
  parameter int AddrWidth          = $clog2(NumVectorRegisters)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,

  input  logic [NumReadPorts-1:0][AddrWidth-1:0] rd_addr_i,
  output vector_t [NumReadPorts-1:0]             rd_data_o,
  output logic [NumReadPorts-1:0]                rd_valid_o,

  input  logic [NumWritePorts-1:0]                wr_en_i,
  input  logic [NumWritePorts-1:0][AddrWidth-1:0] wr_addr_i,
  input  vector_t [NumWritePorts-1:0]             wr_data_i,

  input  logic [NumVectorRegisters-1:0]          inv_i,

  input  logic                                   tm_row_valid_i,
  output logic                                   tm_row_ready_o,
  input  ternary_row_t                           tm_row_data_i,
  input  logic                                   tm_abort_i,
  input  logic                                   tm_release_i,
  output logic                                   tm_active_valid_o,
  output ternary_row_t [MatrixRows-1:0]          tm_data_o
);

  // Storage is flop based: reads are combinational and the whole array
  // must clear on reset, neither of which a block RAM offers.
  vector_t [NumVectorRegisters-1:0] vec_q, vec_d;
  logic [NumVectorRegisters-1:0]    valid_q, valid_d;

  always_comb begin
    vec_d   = vec_q;
    // Invalidate first so a same-cycle write to that register re-sets valid.
    valid_d = valid_q & ~inv_i;
    // Ascending port order: the highest-index port writing an address wins.
    for (int p = 0; p < NumWritePorts; p++) begin
      if (wr_en_i[p]) begin
        vec_d[wr_addr_i[p]]   = wr_data_i[p];
        valid_d[wr_addr_i[p]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vec_q   <= '0;
      valid_q <= '0;
    end else begin
      vec_q   <= vec_d;
      valid_q <= valid_d;
    end
  end

  for (genvar gi = 0; gi < NumReadPorts; gi++) begin : g_rd
    assign rd_data_o[gi]  = vec_q[rd_addr_i[gi]];
    assign rd_valid_o[gi] = valid_q[rd_addr_i[gi]];
  end

  tm_double_buffer #(
    .MatrixRows (MatrixRows)
  ) u_tm_double_buffer (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .row_valid_i    (tm_row_valid_i),
    .row_ready_o    (tm_row_ready_o),
    .row_data_i     (tm_row_data_i),
    .abort_i        (tm_abort_i),
    .release_i      (tm_release_i),
    .active_valid_o (tm_active_valid_o),
    .active_o       (tm_data_o)
  );

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;
  import register_file_mp_pkg::*;

  localparam int NRegs = 8;
  localparam int NRd   = 2;
  localparam int NWr   = 2;
  localparam int Rows  = 4;
  localparam int AW    = 3;
  localparam int RW    = $bits(ternary_row_t);
  localparam int MW    = Rows * RW;

  logic clk = 1'b0;
  logic rst;

  logic [NRd-1:0][AW-1:0] rd_addr;
  vector_t [NRd-1:0]      rd_data;
  logic [NRd-1:0]         rd_valid;
  logic [NWr-1:0]         wr_en;
  logic [NWr-1:0][AW-1:0] wr_addr;
  vector_t [NWr-1:0]      wr_data;
  logic [NRegs-1:0]       inv;

  logic                       tm_row_valid;
  logic                       tm_row_ready;
  ternary_row_t               tm_row_data;
  logic                       tm_abort;
  logic                       tm_release;
  logic                       tm_active_valid;
  ternary_row_t [Rows-1:0]    tm_data;

  int check_count = 0;
  int error_count = 0;

  string       tag_q[$];
  logic [63:0] exp_q[$];

  register_file_mp #(
    .NumVectorRegisters (NRegs),
    .NumReadPorts       (NRd),
    .NumWritePorts      (NWr),
    .MatrixRows         (Rows),
    .AddrWidth          (AW)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .rd_addr_i         (rd_addr),
    .rd_data_o         (rd_data),
    .rd_valid_o        (rd_valid),
    .wr_en_i           (wr_en),
    .wr_addr_i         (wr_addr),
    .wr_data_i         (wr_data),
    .inv_i             (inv),
    .tm_row_valid_i    (tm_row_valid),
    .tm_row_ready_o    (tm_row_ready),
    .tm_row_data_i     (tm_row_data),
    .tm_abort_i        (tm_abort),
    .tm_release_i      (tm_release),
    .tm_active_valid_o (tm_active_valid),
    .tm_data_o         (tm_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_count++;
    if (obs !== exp) begin
      error_count++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic sb_push(input string tag, input logic [63:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_pop_check(input logic [63:0] obs);
    if (tag_q.size() == 0) begin
      check_eq("sb_underflow", 64'(tag_q.size()), 64'd1);
    end else begin
      check_eq(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream Rows rows back-to-back; checks ready on every beat. Returns just
  // after the edge that accepted the last row, with row_valid dropped.
  task automatic stream_matrix(input logic [MW-1:0] m, input string name);
    for (int i = 0; i < Rows; i++) begin
      tm_row_valid = 1'b1;
      tm_row_data  = m[i*RW +: RW];
      #1;
      sb_push($sformatf("%s_ready%0d", name, i), 64'd1);
      sb_pop_check(64'(tm_row_ready));
      tick();
    end
    tm_row_valid = 1'b0;
  endtask

  logic [MW-1:0] m1, m2, xm, fm, gm, hm, km;
  vector_t da, db, dc, dd;

  initial begin
    rst = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; inv = '0;
    tm_row_valid = 1'b0; tm_row_data = '0; tm_abort = 1'b0; tm_release = 1'b0;
    m1 = {$urandom, $urandom}; m2 = {$urandom, $urandom}; xm = {$urandom, $urandom};
    fm = {$urandom, $urandom}; gm = {$urandom, $urandom}; hm = {$urandom, $urandom};
    km = {$urandom, $urandom};
    da = vector_t'($urandom); db = vector_t'($urandom) | 32'h1; dc = vector_t'($urandom) | 32'h2;
    dd = vector_t'($urandom) | 32'h4;
    tick(); tick();
    rst = 1'b0;

    // 1: reset state on every address and port
    for (int a = 0; a < NRegs; a++) begin
      rd_addr[0] = AW'(a);
      rd_addr[1] = AW'(NRegs - 1 - a);
      #1;
      sb_push($sformatf("rst_data0_a%0d", a), 64'd0);  sb_pop_check(64'(rd_data[0]));
      sb_push($sformatf("rst_data1_a%0d", a), 64'd0);  sb_pop_check(64'(rd_data[1]));
      sb_push($sformatf("rst_valid_a%0d", a), 64'd0);  sb_pop_check(64'(rd_valid));
    end
    sb_push("rst_ready", 64'd1);        sb_pop_check(64'(tm_row_ready));
    sb_push("rst_active_valid", 64'd0); sb_pop_check(64'(tm_active_valid));
    sb_push("rst_tm_data", 64'd0);      sb_pop_check(64'(tm_data));

    // 2: two ports to reg 3 in one cycle, highest port wins, no bypass
    wr_en = 2'b11; wr_addr[0] = 3'd3; wr_addr[1] = 3'd3; wr_data[0] = da; wr_data[1] = db;
    rd_addr[0] = 3'd3;
    #1;
    sb_push("wr_same_cycle_data", 64'd0);  sb_pop_check(64'(rd_data[0]));
    sb_push("wr_same_cycle_valid", 64'd0); sb_pop_check(64'(rd_valid[0]));
    sb_push("wr_prio_data", 64'(db));
    sb_push("wr_prio_valid", 64'd1);
    tick();
    wr_en = '0;
    #1;
    sb_pop_check(64'(rd_data[0]));
    sb_pop_check(64'(rd_valid[0]));

    // 3: write beats invalidate on the same register; invalidate alone clears
    wr_en = 2'b01; wr_addr[0] = 3'd5; wr_data[0] = dc; inv = 8'h20;
    rd_addr[1] = 3'd5;
    sb_push("wr_inv_valid", 64'd1);
    tick();
    wr_en = '0; inv = '0;
    #1;
    sb_pop_check(64'(rd_valid[1]));
    inv = 8'h20;
    sb_push("inv_valid", 64'd0);
    sb_push("inv_data_kept", 64'(dc));
    sb_push("inv_other_valid", 64'd1);
    tick();
    inv = '0;
    #1;
    sb_pop_check(64'(rd_valid[1]));
    sb_pop_check(64'(rd_data[1]));
    sb_pop_check(64'(rd_valid[0]));

    // 4: first matrix, active empty: one-cycle ready drop, valid at N+2
    stream_matrix(m1, "m1");
    #1;
    sb_push("m1_ready_n1", 64'd0); sb_pop_check(64'(tm_row_ready));
    sb_push("m1_av_n1", 64'd0);    sb_pop_check(64'(tm_active_valid));
    sb_push("m1_ready_n2", 64'd1);
    sb_push("m1_av_n2", 64'd1);
    sb_push("m1_data", 64'(m1));
    tick();
    sb_pop_check(64'(tm_row_ready));
    sb_pop_check(64'(tm_active_valid));
    sb_pop_check(64'(tm_data));

    // 5: second matrix waits in shadow until release, then swaps without a bubble
    stream_matrix(m2, "m2");
    for (int k = 0; k < 3; k++) begin
      #1;
      sb_push($sformatf("m2_hold_ready%0d", k), 64'd0);  sb_pop_check(64'(tm_row_ready));
      sb_push($sformatf("m2_hold_av%0d", k), 64'd1);     sb_pop_check(64'(tm_active_valid));
      sb_push($sformatf("m2_hold_data%0d", k), 64'(m1)); sb_pop_check(64'(tm_data));
      tick();
    end
    tm_release = 1'b1;
    sb_push("m2_swap_av", 64'd1);
    sb_push("m2_swap_data", 64'(m2));
    sb_push("m2_swap_ready", 64'd1);
    tick();
    tm_release = 1'b0;
    #1;
    sb_pop_check(64'(tm_active_valid));
    sb_pop_check(64'(tm_data));
    sb_pop_check(64'(tm_row_ready));

    // release with nothing pending empties the slot but keeps the data
    tm_release = 1'b1;
    sb_push("rel_av", 64'd0);
    sb_push("rel_data_kept", 64'(m2));
    tick();
    tm_release = 1'b0;
    #1;
    sb_pop_check(64'(tm_active_valid));
    sb_pop_check(64'(tm_data));

    // 6: two rows, abort with a third row, then four fresh rows
    for (int i = 0; i < 2; i++) begin
      tm_row_valid = 1'b1; tm_row_data = xm[i*RW +: RW];
      tick();
    end
    tm_row_data = xm[2*RW +: RW]; tm_abort = 1'b1;
    tick();
    tm_row_valid = 1'b0; tm_abort = 1'b0;
    stream_matrix(fm, "fm");
    #1;
    sb_push("fm_ready_n1", 64'd0); sb_pop_check(64'(tm_row_ready));
    sb_push("fm_av", 64'd1);
    sb_push("fm_data", 64'(fm));
    tick();
    sb_pop_check(64'(tm_active_valid));
    sb_pop_check(64'(tm_data));

    // abort leaves the active buffer alone while release is still honoured
    tm_abort = 1'b1; tm_release = 1'b1;
    sb_push("abort_rel_av", 64'd0);
    sb_push("abort_rel_data", 64'(fm));
    tick();
    tm_abort = 1'b0; tm_release = 1'b0;
    #1;
    sb_pop_check(64'(tm_active_valid));
    sb_pop_check(64'(tm_data));

    // abort in the would-be swap cycle blocks the swap and empties the shadow
    stream_matrix(gm, "gm");
    tm_abort = 1'b1;
    sb_push("abort_swap_av", 64'd0);
    sb_push("abort_swap_ready", 64'd1);
    sb_push("abort_swap_data", 64'(fm));
    sb_push("abort_swap_av_later", 64'd0);
    tick();
    tm_abort = 1'b0;
    #1;
    sb_pop_check(64'(tm_active_valid));
    sb_pop_check(64'(tm_row_ready));
    sb_pop_check(64'(tm_data));
    tick();
    sb_pop_check(64'(tm_active_valid));

    // reset mid-stream with a live active matrix and a written vector
    stream_matrix(hm, "hm");
    tick();
    sb_push("hm_av", 64'd1);    sb_pop_check(64'(tm_active_valid));
    sb_push("hm_data", 64'(hm)); sb_pop_check(64'(tm_data));
    wr_en = 2'b10; wr_addr[1] = 3'd6; wr_data[1] = dd;
    tick();
    wr_en = '0;
    for (int i = 0; i < 2; i++) begin
      tm_row_valid = 1'b1; tm_row_data = km[i*RW +: RW];
      tick();
    end
    tm_row_valid = 1'b0;
    rst = 1'b1;
    rd_addr[0] = 3'd6;
    sb_push("mrst_ready", 64'd1);
    sb_push("mrst_av", 64'd0);
    sb_push("mrst_tm_data", 64'd0);
    sb_push("mrst_rd_data", 64'd0);
    sb_push("mrst_rd_valid", 64'd0);
    tick();
    rst = 1'b0;
    #1;
    sb_pop_check(64'(tm_row_ready));
    sb_pop_check(64'(tm_active_valid));
    sb_pop_check(64'(tm_data));
    sb_pop_check(64'(rd_data[0]));
    sb_pop_check(64'(rd_valid[0]));

    // row counter restarted: a full matrix after reset lands intact
    stream_matrix(km, "km");
    tick();
    sb_push("km_av", 64'd1);     sb_pop_check(64'(tm_active_valid));
    sb_push("km_data", 64'(km)); sb_pop_check(64'(tm_data));

    check_eq("sb_drained", 64'(tag_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
